// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register.
//   - Default widths: N (operand/immediate), R (register address), CW (control word).
//   - Operand-mux select encoding, shared by operand A and operand B.
//   - REG_ZERO: the hard-wired zero register, which never takes part in forwarding.
package id_ex_stage_pkg;

  localparam int unsigned N  = 32;
  localparam int unsigned R  = 5;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register-file data
    FWD_EXMEM = 2'b01,  // EX/MEM ALU result
    FWD_MEMWB = 2'b10,  // MEM/WB writeback value
    FWD_IMM   = 2'b11   // immediate, operand B only
  } fwd_sel_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side, hazard-side and EX-side signals of the ID/EX register.
//   master: decode/hazard logic (drives id_*, flush, hold, exmem_*; sees stall, ex_*)
//   slave : the id_ex_stage register itself
interface id_ex_stage_if #(
  parameter int unsigned N  = id_ex_stage_pkg::N,
  parameter int unsigned R  = id_ex_stage_pkg::R,
  parameter int unsigned CW = id_ex_stage_pkg::CW
);
  import id_ex_stage_pkg::*;

  // Decode side
  logic          id_valid;
  logic [R-1:0]  id_rs;
  logic [R-1:0]  id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          id_alu_src_imm;
  logic [R-1:0]  id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic [N-1:0]  id_rs_data;
  logic [N-1:0]  id_rt_data;
  logic [N-1:0]  id_imm;
  logic [CW-1:0] id_ctrl;

  // Hazard/branch control and the instruction currently in EX/MEM
  logic          flush;
  logic          hold;
  logic          exmem_reg_write;
  logic [R-1:0]  exmem_rd;

  // Outputs
  logic          stall;
  logic          ex_valid;
  logic [N-1:0]  ex_rs_data;
  logic [N-1:0]  ex_rt_data;
  logic [N-1:0]  ex_imm;
  logic [R-1:0]  ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [CW-1:0] ex_ctrl;
  logic [1:0]    ex_fwd_a_sel;
  logic [1:0]    ex_fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_alu_src_imm, id_rd,
           id_reg_write, id_mem_read, id_rs_data, id_rt_data, id_imm, id_ctrl,
           flush, hold, exmem_reg_write, exmem_rd,
    input  stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_reg_write,
           ex_mem_read, ex_ctrl, ex_fwd_a_sel, ex_fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_alu_src_imm, id_rd,
           id_reg_write, id_mem_read, id_rs_data, id_rt_data, id_imm, id_ctrl,
           flush, hold, exmem_reg_write, exmem_rd,
    output stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_reg_write,
           ex_mem_read, ex_ctrl, ex_fwd_a_sel, ex_fwd_b_sel
  );

endinterface

// File: rtl/id_ex_stage_fwd_sel_gen.sv
// Combinational forwarding-select generator for one EX operand.
//   uses_i            : the instruction in ID reads this source
//   src_i             : source register number
//   alu_src_imm_i     : operand is the immediate (honoured only when ImmOverride=1)
//   ex_*_i            : the instruction now in EX (it will sit in EX/MEM next cycle)
//   exmem_*_i         : the instruction now in EX/MEM (it will sit in MEM/WB next cycle)
//   sel_o             : select to be registered alongside the instruction
module id_ex_stage_fwd_sel_gen #(
  parameter int unsigned R           = id_ex_stage_pkg::R,
  parameter bit          ImmOverride = 1'b0
) (
  input  logic         uses_i,
  input  logic [R-1:0] src_i,
  input  logic         alu_src_imm_i,
  input  logic         ex_valid_i,
  input  logic         ex_reg_write_i,
  input  logic [R-1:0] ex_rd_i,
  input  logic         exmem_reg_write_i,
  input  logic [R-1:0] exmem_rd_i,
  output logic [1:0]   sel_o
);
  import id_ex_stage_pkg::*;

  logic src_nonzero;
  logic ex_hit;
  logic exmem_hit;

  assign src_nonzero = (src_i != R'(REG_ZERO));
  assign ex_hit      = ex_valid_i & ex_reg_write_i & (ex_rd_i == src_i) & src_nonzero;
  assign exmem_hit   = exmem_reg_write_i & (exmem_rd_i == src_i) & src_nonzero;

  // The EX instruction is younger than the EX/MEM one, so its value wins.
  always_comb begin
    sel_o = FWD_RF;
    if (ImmOverride && alu_src_imm_i) begin
      sel_o = FWD_IMM;
    end else if (uses_i && ex_hit) begin
      sel_o = FWD_EXMEM;
    end else if (uses_i && exmem_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and registered forwarding selects.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : id_ex_stage_if slave port (ID inputs, flush/hold, EX/MEM destination,
//            combinational stall, registered ex_* outputs and operand-mux selects)
// Update priority on each edge: reset > flush > hold > load-use bubble > load.
module id_ex_stage #(
  parameter int unsigned N  = id_ex_stage_pkg::N,
  parameter int unsigned R  = id_ex_stage_pkg::R,
  parameter int unsigned CW = id_ex_stage_pkg::CW
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  id_ex_stage_if.slave bus
);
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic          valid;
    logic [N-1:0]  rs_data;
    logic [N-1:0]  rt_data;
    logic [N-1:0]  imm;
    logic [R-1:0]  rd;
    logic          reg_write;
    logic          mem_read;
    logic [CW-1:0] ctrl;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d, id_pkt;

  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       load_in_ex;
  logic       rs_hazard;
  logic       rt_hazard;
  logic       stall;

  id_ex_stage_fwd_sel_gen #(
    .R          (R),
    .ImmOverride(1'b0)
  ) u_fwd_a (
    .uses_i           (bus.id_uses_rs),
    .src_i            (bus.id_rs),
    .alu_src_imm_i    (1'b0),
    .ex_valid_i       (ex_q.valid),
    .ex_reg_write_i   (ex_q.reg_write),
    .ex_rd_i          (ex_q.rd),
    .exmem_reg_write_i(bus.exmem_reg_write),
    .exmem_rd_i       (bus.exmem_rd),
    .sel_o            (fwd_a_sel)
  );

  id_ex_stage_fwd_sel_gen #(
    .R          (R),
    .ImmOverride(1'b1)
  ) u_fwd_b (
    .uses_i           (bus.id_uses_rt),
    .src_i            (bus.id_rt),
    .alu_src_imm_i    (bus.id_alu_src_imm),
    .ex_valid_i       (ex_q.valid),
    .ex_reg_write_i   (ex_q.reg_write),
    .ex_rd_i          (ex_q.rd),
    .exmem_reg_write_i(bus.exmem_reg_write),
    .exmem_rd_i       (bus.exmem_rd),
    .sel_o            (fwd_b_sel)
  );

  // A load in EX cannot forward until it reaches MEM/WB's input, so a dependent
  // instruction in ID waits one cycle. rt only matters when B is not the immediate.
  assign load_in_ex = ex_q.valid & ex_q.mem_read & ex_q.reg_write &
                      (ex_q.rd != R'(REG_ZERO));
  assign rs_hazard  = bus.id_uses_rs & (bus.id_rs == ex_q.rd);
  assign rt_hazard  = bus.id_uses_rt & ~bus.id_alu_src_imm & (bus.id_rt == ex_q.rd);
  assign stall      = bus.id_valid & load_in_ex & (rs_hazard | rt_hazard) &
                      ~bus.flush & ~bus.hold;

  always_comb begin
    id_pkt           = '0;
    id_pkt.valid     = bus.id_valid;
    id_pkt.rs_data   = bus.id_rs_data;
    id_pkt.rt_data   = bus.id_rt_data;
    id_pkt.imm       = bus.id_imm;
    id_pkt.rd        = bus.id_rd;
    id_pkt.reg_write = bus.id_reg_write;
    id_pkt.mem_read  = bus.id_mem_read;
    id_pkt.ctrl      = bus.id_ctrl;
    id_pkt.fwd_a     = fwd_a_sel;
    id_pkt.fwd_b     = fwd_b_sel;
  end

  // A bubble is an all-zero slot: invalid, no write, no load, selects at FWD_RF.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.hold) begin
      ex_d = ex_q;
    end else if (stall) begin
      ex_d = '0;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_rs_data   = ex_q.rs_data;
  assign bus.ex_rt_data   = ex_q.rt_data;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.ex_fwd_a_sel = ex_q.fwd_a;
  assign bus.ex_fwd_b_sel = ex_q.fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  id_ex_stage_if #(.N(32), .R(5), .CW(8)) bus ();

  id_ex_stage #(.N(32), .R(5), .CW(8)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt;
    logic        uses_rs, uses_rt, imm_sel;
    logic [4:0]  rd;
    logic        rw, mr;
    logic [31:0] rs_data, rt_data, imm;
    logic [7:0]  ctrl;
    logic        flush, hold, xm_rw;
    logic [4:0]  xm_rd;
  } in_t;

  typedef struct {
    in_t        in;
    logic       stall;
    logic       valid;
    logic [1:0] a, b;
  } vec_t;

  // Expected contents of the EX slot
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rd;
    logic        rw, mr;
    logic [7:0]  ctrl;
    logic [1:0]  a, b;
  } em_t;

  int tests = 0;
  int fails = 0;
  em_t m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                             input logic urt, input logic imm_sel, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic fl, input logic hd,
                             input logic xrw, input logic [4:0] xrd);
    in_t v;
    v.valid = 1'b1; v.rs = rs; v.rt = rt; v.uses_rs = urs; v.uses_rt = urt;
    v.imm_sel = imm_sel; v.rd = rd; v.rw = rw; v.mr = mr;
    v.rs_data = $urandom; v.rt_data = $urandom; v.imm = $urandom; v.ctrl = 8'($urandom);
    v.flush = fl; v.hold = hd; v.xm_rw = xrw; v.xm_rd = xrd;
    return v;
  endfunction

  // Nearest writer of src among the in-flight instructions, youngest first.
  function automatic logic [1:0] m_sel(input logic uses, input logic [4:0] src,
                                       input logic is_b, input logic imm_sel, input em_t ex,
                                       input logic xrw, input logic [4:0] xrd);
    logic [4:0] prd [2];
    logic       pw  [2];
    logic [1:0] code[2];
    if (is_b && imm_sel) return 2'b11;
    if (!uses || src == 5'd0) return 2'b00;
    prd[0] = ex.rd; pw[0] = ex.valid && ex.rw; code[0] = 2'b01;
    prd[1] = xrd;   pw[1] = xrw;               code[1] = 2'b10;
    for (int k = 0; k < 2; k++) if (pw[k] && prd[k] == src) return code[k];
    return 2'b00;
  endfunction

  function automatic logic m_stall(input in_t v, input em_t ex);
    if (!v.valid || !ex.valid || !ex.mr || !ex.rw || ex.rd == 5'd0 || v.flush || v.hold)
      return 1'b0;
    return (v.uses_rs && v.rs == ex.rd) || (v.uses_rt && !v.imm_sel && v.rt == ex.rd);
  endfunction

  function automatic em_t m_next(input in_t v, input logic rst_n, input em_t ex);
    em_t n;
    if (!rst_n || v.flush) return '0;
    if (v.hold) return ex;
    if (m_stall(v, ex)) return '0;
    n.valid = v.valid; n.rs_data = v.rs_data; n.rt_data = v.rt_data; n.imm = v.imm;
    n.rd = v.rd; n.rw = v.rw; n.mr = v.mr; n.ctrl = v.ctrl;
    n.a = m_sel(v.uses_rs, v.rs, 1'b0, 1'b0, ex, v.xm_rw, v.xm_rd);
    n.b = m_sel(v.uses_rt, v.rt, 1'b1, v.imm_sel, ex, v.xm_rw, v.xm_rd);
    return n;
  endfunction

  task automatic apply(input in_t v);
    bus.id_valid = v.valid; bus.id_rs = v.rs; bus.id_rt = v.rt;
    bus.id_uses_rs = v.uses_rs; bus.id_uses_rt = v.uses_rt; bus.id_alu_src_imm = v.imm_sel;
    bus.id_rd = v.rd; bus.id_reg_write = v.rw; bus.id_mem_read = v.mr;
    bus.id_rs_data = v.rs_data; bus.id_rt_data = v.rt_data; bus.id_imm = v.imm;
    bus.id_ctrl = v.ctrl; bus.flush = v.flush; bus.hold = v.hold;
    bus.exmem_reg_write = v.xm_rw; bus.exmem_rd = v.xm_rd;
  endtask

  // Drive one cycle: sample stall mid-cycle, advance model at the edge, settle #1.
  task automatic step(input in_t v, output logic st_act, output logic st_exp);
    apply(v);
    #3;
    st_act = bus.stall;
    st_exp = m_stall(v, m);
    @(posedge clk_i);
    m = m_next(v, rst_ni, m);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/valid"}, 64'(bus.ex_valid), 64'(m.valid));
    chk({tag, "/rs_data"}, 64'(bus.ex_rs_data), 64'(m.rs_data));
    chk({tag, "/rt_data"}, 64'(bus.ex_rt_data), 64'(m.rt_data));
    chk({tag, "/imm"}, 64'(bus.ex_imm), 64'(m.imm));
    chk({tag, "/rd"}, 64'(bus.ex_rd), 64'(m.rd));
    chk({tag, "/reg_write"}, 64'(bus.ex_reg_write), 64'(m.rw));
    chk({tag, "/mem_read"}, 64'(bus.ex_mem_read), 64'(m.mr));
    chk({tag, "/ctrl"}, 64'(bus.ex_ctrl), 64'(m.ctrl));
    chk({tag, "/a_sel"}, 64'(bus.ex_fwd_a_sel), 64'(m.a));
    chk({tag, "/b_sel"}, 64'(bus.ex_fwd_b_sel), 64'(m.b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  vecs[16];
    in_t   v;
    logic  sa, se;
    logic [31:0] frozen_rs;

    // Directed vectors: {ID instruction + side inputs, stall, ex_valid, a_sel, b_sel}
    vecs[0]  = '{mk(1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0),   0, 1, 2'b00, 2'b00}; // add r3
    vecs[1]  = '{mk(3, 4, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0),   0, 1, 2'b01, 2'b00}; // sub r5,r3,r4
    vecs[2]  = '{mk(5, 4, 1, 1, 0, 7, 1, 0, 0, 0, 1, 4),   0, 1, 2'b01, 2'b10}; // r4 in EX/MEM
    vecs[3]  = '{mk(7, 0, 1, 1, 0, 2, 1, 1, 0, 0, 1, 7),   0, 1, 2'b01, 2'b00}; // nearest; lw r2
    vecs[4]  = '{mk(2, 1, 1, 1, 0, 6, 1, 0, 0, 0, 1, 7),   1, 0, 2'b00, 2'b00}; // add r6,r2,r1
    vecs[5]  = '{mk(2, 1, 1, 1, 0, 6, 1, 0, 0, 0, 1, 2),   0, 1, 2'b10, 2'b00}; // re-presented
    vecs[6]  = '{mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0),   0, 1, 2'b00, 2'b00}; // lw r0
    vecs[7]  = '{mk(0, 0, 1, 1, 0, 8, 1, 1, 0, 0, 1, 0),   0, 1, 2'b00, 2'b00}; // reads r0; lw r8
    vecs[8]  = '{mk(9, 8, 1, 1, 1, 10, 1, 1, 0, 0, 0, 0),  0, 1, 2'b00, 2'b11}; // addi; lw r10
    vecs[9]  = '{mk(10, 1, 1, 1, 0, 12, 1, 0, 1, 0, 0, 0), 0, 0, 2'b00, 2'b00}; // load-use+flush
    vecs[10] = '{mk(1, 2, 1, 1, 0, 11, 1, 1, 0, 0, 1, 1),  0, 1, 2'b10, 2'b00}; // lw r11
    vecs[11] = '{mk(11, 11, 1, 1, 0, 13, 1, 0, 0, 1, 0, 0), 0, 1, 2'b10, 2'b00}; // hold
    vecs[12] = '{mk(11, 11, 1, 1, 0, 13, 1, 0, 0, 1, 0, 0), 0, 1, 2'b10, 2'b00}; // hold
    vecs[13] = '{mk(11, 11, 1, 1, 0, 13, 1, 0, 0, 1, 0, 0), 0, 1, 2'b10, 2'b00}; // hold
    vecs[14] = '{mk(11, 3, 1, 1, 0, 14, 1, 0, 1, 1, 0, 0),  0, 0, 2'b00, 2'b00}; // hold+flush
    vecs[15] = '{mk(1, 2, 1, 1, 0, 15, 1, 0, 0, 0, 0, 0),   0, 1, 2'b00, 2'b00};

    // Reset for two cycles with random inputs
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v = mk(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom));
      v.valid = 1'($urandom);
      step(v, sa, se);
      chk("reset/regs_zero", 64'({bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                                  bus.ex_ctrl, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel}), 64'd0);
      chk("reset/data_zero", 64'(bus.ex_rs_data | bus.ex_rt_data | bus.ex_imm), 64'd0);
      chk("reset/stall", 64'(bus.stall), 64'd0);
    end
    rst_ni = 1'b1;

    // Table-driven directed sequence
    for (int i = 0; i < 16; i++) begin
      if (i == 11) frozen_rs = bus.ex_rs_data;
      step(vecs[i].in, sa, se);
      chk($sformatf("vec%0d/stall", i), 64'(sa), 64'(vecs[i].stall));
      chk($sformatf("vec%0d/ex_valid", i), 64'(bus.ex_valid), 64'(vecs[i].valid));
      chk($sformatf("vec%0d/a_sel", i), 64'(bus.ex_fwd_a_sel), 64'(vecs[i].a));
      chk($sformatf("vec%0d/b_sel", i), 64'(bus.ex_fwd_b_sel), 64'(vecs[i].b));
      if (i >= 11 && i <= 13) begin
        chk($sformatf("vec%0d/held_rs_data", i), 64'(bus.ex_rs_data), 64'(frozen_rs));
        chk($sformatf("vec%0d/held_rd", i), 64'(bus.ex_rd), 64'd11);
      end
      chk_all($sformatf("vec%0d", i));
    end

    // Reset arriving while a load-use stall is asserted
    v = mk(1, 2, 1, 1, 0, 4, 1, 1, 0, 0, 0, 0);       // lw r4
    step(v, sa, se);
    v = mk(4, 2, 1, 1, 0, 6, 1, 0, 0, 0, 0, 0);       // add r6,r4,r2
    rst_ni = 1'b0;
    step(v, sa, se);
    chk("midrst/stall_before", 64'(sa), 64'd1);
    chk("midrst/ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("midrst/stall_after", 64'(bus.stall), 64'd0);
    rst_ni = 1'b1;
    step(v, sa, se);
    chk("midrst/first_stall", 64'(sa), 64'd0);
    chk("midrst/reload_valid", 64'(bus.ex_valid), 64'd1);
    chk_all("midrst");

    // Randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom), 5'($urandom_range(0, 3)));
      v.valid = ($urandom_range(0, 7) != 0);
      rst_ni  = ($urandom_range(0, 49) != 0);
      step(v, sa, se);
      chk($sformatf("rnd%0d/stall", i), 64'(sa), 64'(se));
      chk_all($sformatf("rnd%0d", i));
    end
    rst_ni = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX).
- Captures operands, immediate, destination and control.
- Precomputes registered forwarding selects that drive the EX-stage 4:1 operand muxes (mux_4to1_n).
- Detects load-use hazards, inserts bubbles, and honours flush and hold from hazard/branch logic.

Parameters:
- N, 32, data width of operands and immediate
- R, 5, register-address width
- CW, 8, width of opaque pass-through ALU/mem control word

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  R  source A register number
- id_rt  in  R  source B register number
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_alu_src_imm  in  1  operand B is the immediate
- id_rd  in  R  destination register number
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_rs_data  in  N  register-file value of rs
- id_rt_data  in  N  register-file value of rt
- id_imm  in  N  sign-extended immediate
- id_ctrl  in  CW  remaining control
- flush  in  1  squash the instruction entering EX
- hold  in  1  downstream freeze
- exmem_reg_write  in  1  write-enable of the instruction now in EX/MEM
- exmem_rd  in  R  destination of the instruction now in EX/MEM
- stall  out  1  load-use stall to PC/IF-ID (combinational)
- ex_valid  out  1  registered valid
- ex_rs_data, ex_rt_data, ex_imm  out  N  registered data
- ex_rd  out  R  registered destination
- ex_reg_write, ex_mem_read  out  1  registered control
- ex_ctrl  out  CW  registered control
- ex_fwd_a_sel  out  2  operand-A mux select
- ex_fwd_b_sel  out  2  operand-B mux select

Behaviour:
- Mux select encoding, shared by both operands:
  - 00 = register-file data
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB writeback value
  - 11 = ex_imm (operand B only; never generated for A)
- All state updates on rising clk. Priority order: reset > flush > hold > load-use bubble > normal load.
- Reset (rst_n=0 at edge): every registered output becomes 0, including ex_valid, both selects and all data.
  - stall is combinational and is 0 whenever ex_valid=0.
- Forwarding select, computed in ID and registered with the instruction:
  - Compare against the current EX instruction (ex_rd/ex_reg_write/ex_valid), which is in EX/MEM next cycle → 01.
  - Compare against the current EX/MEM instruction (exmem_rd/exmem_reg_write), which is in MEM/WB next cycle → 10.
  - The EX match has priority over the EX/MEM match.
  - Register 0 never matches.
  - No match → 00.
  - If id_uses_rs=0, A sel=00.
  - B sel=11 whenever id_alu_src_imm=1, regardless of matches.
- Register-file write-through covers MEM/WB→ID, so no third comparison is made.
- Load-use detection: stall=1 when all of the following hold:
  - id_valid & ex_valid & ex_mem_read & ex_reg_write
  - ex_rd≠0
  - (id_uses_rs & id_rs==ex_rd) | (id_uses_rt & !id_alu_src_imm & id_rt==ex_rd)
  - !flush & !hold
- Bubble (on stall or flush): ex_valid, ex_reg_write and ex_mem_read become 0. Selects become 00. Data and ctrl values are don't-care but are zeroed.
- During a stall the ID instruction is re-presented next cycle. Its recomputed select then finds the load via exmem_rd → 10.
- Hold: all registers retain their values and stall=0. A flush during hold still bubbles.
- Latency: exactly 1 cycle ID→EX. Throughput: 1 instruction/cycle absent stall/hold.
- Reset mid-stall clears the pipeline. The first post-reset cycle must produce stall=0.

Decomposition:
- Shared package: fwd_sel encoding constants (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_IMM), REG_ZERO, and default widths N/R/CW.
- One natural sub-module, fwd_sel_gen: combinational select generator for one operand, instantiated twice (B with the imm override enabled).

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs → every output is 0 and stall=0.
- Back-to-back forward:
  - add r3 enters EX, then sub r5,r3,r4 in ID → next cycle ex_fwd_a_sel=01, ex_fwd_b_sel=00.
  - Same case with r4 written by the older EX/MEM instruction → b_sel=10.
  - If both the EX and EX/MEM instructions write r3 → a_sel=01 (nearest wins).
- Load-use:
  - lw r2 in EX, add r6,r2,r1 in ID → stall=1 for one cycle; ex_valid=0 bubble.
  - Following cycle the add enters EX with a_sel=10 and stall=0.
- Zero register and immediate:
  - An EX instruction writing r0 while ID reads r0 → a_sel=00, no stall.
  - addi with id_alu_src_imm=1 and rt matching ex_rd → b_sel=11, no stall.
- Flush vs stall vs hold:
  - Load-use condition plus flush=1 → stall=0 and a bubble is loaded.
  - hold=1 for 3 cycles → outputs frozen at their pre-hold values.
  - hold=1 with flush=1 → bubble.
